// File: rtl/hough_peak_finder_pkg.sv
// Shared Hough accumulator geometry, FSM state type and cell-to-(r, angle) helpers.
// The vote writer uses the same constants, so both sides agree on the address layout.
package hough_peak_finder_pkg;

   localparam int unsigned NUM_ANGLES  = 45;
   localparam int unsigned ANGLE_STEP  = 4;
   localparam int unsigned R_BINS_LOG2 = 11;
   localparam int          R_OFFSET    = 1024;
   localparam int unsigned COUNT_W     = 16;
   localparam int unsigned ADDR_W      = 17;
   localparam int unsigned R_W         = 12;
   localparam int unsigned ANGLE_W     = 8;

   typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

   function automatic logic signed [R_W-1:0] bin_to_r(input logic [15:0] bin);
      return R_W'(int'(bin) - R_OFFSET);
   endfunction

   function automatic logic [ANGLE_W-1:0] row_to_angle(input logic [15:0] row);
      return ANGLE_W'(int'(row) * int'(ANGLE_STEP));
   endfunction

endpackage

// File: rtl/peak_sorter.sv
// Descending-count peak list with single-cycle insertion; equal counts never displace,
// so earlier cells win ties.
module peak_sorter
   import hough_peak_finder_pkg::*;
#(
   parameter int unsigned NUM_PEAKS = 4,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned ROW_W     = 6,
   parameter int unsigned BIN_W     = 11
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic [CNT_W-1:0]      threshold_i,
   input  logic                  in_valid_i,
   input  logic [CNT_W-1:0]      in_count_i,
   input  logic [ROW_W-1:0]      in_row_i,
   input  logic [BIN_W-1:0]      in_bin_i,
   output logic                  valid_o [NUM_PEAKS],
   output logic [CNT_W-1:0]      count_o [NUM_PEAKS],
   output logic signed [R_W-1:0] r_o     [NUM_PEAKS],
   output logic [ANGLE_W-1:0]    angle_o [NUM_PEAKS]
);

   logic                  valid_q [NUM_PEAKS];
   logic                  valid_d [NUM_PEAKS];
   logic [CNT_W-1:0]      count_q [NUM_PEAKS];
   logic [CNT_W-1:0]      count_d [NUM_PEAKS];
   logic signed [R_W-1:0] r_q     [NUM_PEAKS];
   logic signed [R_W-1:0] r_d     [NUM_PEAKS];
   logic [ANGLE_W-1:0]    angle_q [NUM_PEAKS];
   logic [ANGLE_W-1:0]    angle_d [NUM_PEAKS];

   logic [NUM_PEAKS-1:0]  ge;
   logic                  insert;
   logic signed [R_W-1:0] in_r;
   logic [ANGLE_W-1:0]    in_angle;

   assign in_r     = bin_to_r(16'(in_bin_i));
   assign in_angle = row_to_angle(16'(in_row_i));

   always_comb begin
      // ge is monotonic over the sorted list: the first set bit is the insertion slot
      for (int i = 0; i < NUM_PEAKS; i++) begin
         ge[i]      = !valid_q[i] || (in_count_i > count_q[i]);
         valid_d[i] = valid_q[i];
         count_d[i] = count_q[i];
         r_d[i]     = r_q[i];
         angle_d[i] = angle_q[i];
      end
      insert = in_valid_i && (in_count_i >= threshold_i) && ge[NUM_PEAKS-1];
      if (clr_i) begin
         for (int i = 0; i < NUM_PEAKS; i++) begin
            valid_d[i] = 1'b0;
            count_d[i] = '0;
            r_d[i]     = '0;
            angle_d[i] = '0;
         end
      end else if (insert) begin
         if (ge[0]) begin
            valid_d[0] = 1'b1;
            count_d[0] = in_count_i;
            r_d[0]     = in_r;
            angle_d[0] = in_angle;
         end
         for (int i = 1; i < NUM_PEAKS; i++) begin
            if (ge[i] && ge[i-1]) begin
               valid_d[i] = valid_q[i-1];
               count_d[i] = count_q[i-1];
               r_d[i]     = r_q[i-1];
               angle_d[i] = angle_q[i-1];
            end else if (ge[i]) begin
               valid_d[i] = 1'b1;
               count_d[i] = in_count_i;
               r_d[i]     = in_r;
               angle_d[i] = in_angle;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_PEAKS; i++) begin
            valid_q[i] <= 1'b0;
            count_q[i] <= '0;
            r_q[i]     <= '0;
            angle_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PEAKS; i++) begin
            valid_q[i] <= valid_d[i];
            count_q[i] <= count_d[i];
            r_q[i]     <= r_d[i];
            angle_q[i] <= angle_d[i];
         end
      end
   end

   assign valid_o = valid_q;
   assign count_o = count_q;
   assign r_o     = r_q;
   assign angle_o = angle_q;

endmodule

// File: rtl/hough_peak_finder.sv
// Scans the whole Hough accumulator once per start, optionally clearing it behind the read,
// and keeps the NUM_PEAKS strongest cells for readback via peak_sel.
module hough_peak_finder #(
   parameter int unsigned NUM_ANGLES  = hough_peak_finder_pkg::NUM_ANGLES,
   parameter int unsigned R_BINS_LOG2 = hough_peak_finder_pkg::R_BINS_LOG2,
   parameter int unsigned COUNT_W     = hough_peak_finder_pkg::COUNT_W,
   parameter int unsigned NUM_PEAKS   = 4,
   parameter int unsigned RD_LATENCY  = 2,
   localparam int unsigned SEL_W      = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1
) (
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic                                             start,
   input  logic [COUNT_W-1:0]                               threshold,
   input  logic                                             clear_en,
   output logic                                             busy,
   output logic                                             done,
   output logic [hough_peak_finder_pkg::ADDR_W-1:0]         acc_raddr,
   input  logic [COUNT_W-1:0]                               acc_rdata,
   output logic                                             acc_we,
   output logic [hough_peak_finder_pkg::ADDR_W-1:0]         acc_waddr,
   output logic [COUNT_W-1:0]                               acc_wdata,
   input  logic [SEL_W-1:0]                                 peak_sel,
   output logic                                             peak_valid,
   output logic signed [hough_peak_finder_pkg::R_W-1:0]     peak_r,
   output logic [hough_peak_finder_pkg::ANGLE_W-1:0]        peak_angle,
   output logic [COUNT_W-1:0]                               peak_count
);

   import hough_peak_finder_pkg::*;

   localparam int unsigned       ROW_W     = ADDR_W - R_BINS_LOG2;
   localparam int unsigned       NUM_CELLS = NUM_ANGLES << R_BINS_LOG2;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);

   state_e              state_q;
   logic [ADDR_W-1:0]   raddr_q;
   logic                addr_vld_q;
   logic [ADDR_W-1:0]   pipe_addr_q [RD_LATENCY];
   logic                pipe_vld_q  [RD_LATENCY];
   logic [COUNT_W-1:0]  thresh_q;
   logic                clr_q;
   logic                done_q;

   logic                cons_vld;
   logic [ADDR_W-1:0]   cons_addr;
   logic                list_clr;

   logic                  ent_valid [NUM_PEAKS];
   logic [COUNT_W-1:0]    ent_count [NUM_PEAKS];
   logic signed [R_W-1:0] ent_r     [NUM_PEAKS];
   logic [ANGLE_W-1:0]    ent_angle [NUM_PEAKS];

   // The last pipeline stage lines up with acc_rdata for the address it carries
   assign cons_vld  = pipe_vld_q[RD_LATENCY-1];
   assign cons_addr = pipe_addr_q[RD_LATENCY-1];
   assign list_clr  = start && (state_q == StIdle);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         raddr_q    <= '0;
         addr_vld_q <= 1'b0;
         thresh_q   <= '0;
         clr_q      <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_addr_q[i] <= '0;
            pipe_vld_q[i]  <= 1'b0;
         end
      end else begin
         done_q         <= 1'b0;
         pipe_addr_q[0] <= raddr_q;
         pipe_vld_q[0]  <= addr_vld_q;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_addr_q[i] <= pipe_addr_q[i-1];
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
         end
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q    <= StScan;
                  raddr_q    <= '0;
                  addr_vld_q <= 1'b1;
                  thresh_q   <= threshold;
                  clr_q      <= clear_en;
               end
            end
            StScan: begin
               if (raddr_q == LAST_ADDR) begin
                  addr_vld_q <= 1'b0;
                  state_q    <= StDrain;
               end else begin
                  raddr_q <= raddr_q + ADDR_W'(1);
               end
            end
            StDrain: begin
               if (cons_vld && (cons_addr == LAST_ADDR)) begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign acc_raddr = raddr_q;
   assign acc_we    = cons_vld && clr_q;
   assign acc_waddr = cons_addr;
   assign acc_wdata = '0;

   peak_sorter #(
      .NUM_PEAKS (NUM_PEAKS),
      .CNT_W     (COUNT_W),
      .ROW_W     (ROW_W),
      .BIN_W     (R_BINS_LOG2)
   ) u_sorter (
      .clk_i       (clk),
      .rst_i       (reset),
      .clr_i       (list_clr),
      .threshold_i (thresh_q),
      .in_valid_i  (cons_vld),
      .in_count_i  (acc_rdata),
      .in_row_i    (cons_addr[ADDR_W-1:R_BINS_LOG2]),
      .in_bin_i    (cons_addr[R_BINS_LOG2-1:0]),
      .valid_o     (ent_valid),
      .count_o     (ent_count),
      .r_o         (ent_r),
      .angle_o     (ent_angle)
   );

   always_comb begin
      peak_valid = 1'b0;
      peak_r     = '0;
      peak_angle = '0;
      peak_count = '0;
      for (int i = 0; i < NUM_PEAKS; i++) begin
         if (SEL_W'(i) == peak_sel) begin
            peak_valid = ent_valid[i];
            peak_r     = ent_r[i];
            peak_angle = ent_angle[i];
            peak_count = ent_count[i];
         end
      end
   end

endmodule

// File: doc/hough_peak_finder.md
HOUGH_PEAK_FINDER -- requirements
Module: hough_peak_finder

Interface
REQ-001 SHALL have parameter NUM_ANGLES, default 45, meaning the number of angle rows in the accumulator, at angle code = 4*row.
REQ-002 SHALL have parameter R_BINS_LOG2, default 11, meaning 2048 r bins, where r = bin - 1024.
REQ-003 SHALL have parameter COUNT_W, default 16, meaning the vote count width.
REQ-004 SHALL have parameter NUM_PEAKS, default 4, meaning the number of entries in the peak list.
REQ-005 SHALL have parameter RD_LATENCY, default 2, meaning the accumulator read latency in cycles.
REQ-006 SHALL have these ports, with clock and reset first:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; begin a scan.
- threshold  in  COUNT_W  minimum count for a peak.
- clear_en  in  1  sampled at start; write zero after reading each cell.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when the scan completes.
- acc_raddr  out  17  accumulator read address = row*2048 + bin.
- acc_rdata  in  COUNT_W  read data, valid RD_LATENCY cycles after the address.
- acc_we  out  1  clear-write enable.
- acc_waddr  out  17  clear-write address.
- acc_wdata  out  COUNT_W  always zero.
- peak_sel  in  log2(NUM_PEAKS)  selects a peak-list entry.
- peak_valid  out  1  selected entry holds a peak.
- peak_r  out  12 signed  r of the selected entry.
- peak_angle  out  8  angle code of the selected entry.
- peak_count  out  COUNT_W  vote count of the selected entry.

Function
REQ-007 SHALL implement the FSM states IDLE, SCAN and DRAIN.
REQ-008 SHALL transition IDLE->SCAN on start, SCAN->DRAIN after the last address is issued, and DRAIN->IDLE when the last datum has been processed.
REQ-009 SHALL, on start in IDLE, clear all peak entries to invalid and latch threshold and clear_en.
REQ-010 SHALL ignore start while busy is high.
REQ-011 SHALL issue addresses 0..NUM_ANGLES*2^R_BINS_LOG2-1, one per cycle, in ascending order, beginning in the cycle after start is sampled.
REQ-012 SHALL carry the address through a delay pipeline of depth RD_LATENCY, so that each acc_rdata is paired with its own row and bin.
REQ-013 SHALL, when clear_en is latched, pulse acc_we in the cycle acc_rdata is consumed, with acc_waddr equal to the paired address.
REQ-014 SHALL keep acc_we low when clear_en is not latched.
REQ-015 SHALL keep the peak list sorted by descending count, with entry 0 the largest.
REQ-016 SHALL insert a datum only if count >= threshold and count > the smallest valid entry's count, or if any entry is still invalid.
REQ-017 SHALL insert by shifting lower entries down and discarding the last entry.
REQ-018 SHALL break ties in favour of the earlier address: an equal count never displaces and is inserted below existing equal entries.
REQ-019 SHALL complete each insertion in one cycle.
REQ-020 SHALL sustain one datum per cycle with no stall.
REQ-021 SHALL store peak_r = bin - 1024 (sign-correct 12 bit) and peak_angle = 4*row, truncated to 8 bits.
REQ-022 SHALL make the peak_* outputs a combinational function of peak_sel and the registered list.
REQ-023 SHALL make the peak_* outputs stable from done until the next accepted start.
REQ-024 SHALL assert done for exactly one cycle, RD_LATENCY+1 cycles after the last address is issued; busy falls in the same cycle.
REQ-025 SHALL, with the defaults, assert done in cycle k+92160+3 when start is sampled in cycle k.
REQ-026 SHALL treat threshold = 0 as meaning every cell qualifies, so that a scan of an all-zero accumulator yields NUM_PEAKS valid entries with count 0.

Reset
REQ-027 SHALL, on reset assertion, immediately force: state IDLE, busy 0, done 0, acc_we 0, acc_raddr 0, all peak entries invalid with zero fields, and the pipeline valid bits cleared.
REQ-028 SHALL, on reset mid-scan, abort the scan with no done pulse and issue no further clear-writes.
REQ-029 SHALL NOT reset the accumulator contents.

Structure
REQ-030 SHALL place NUM_ANGLES, ANGLE_STEP (4), R_BINS_LOG2, R_OFFSET (1024) and COUNT_W in a shared package, also used by hough_transformer's vote writer.
REQ-031 SHALL place the peak list in one sub-module, peak_sorter, which takes a valid/count/row/bin input and exposes the sorted entries.
REQ-032 SHALL keep the FSM, address counter and delay pipeline in hough_peak_finder.

Verification
REQ-033 SHALL cover: all-zero memory, threshold 1 -> done at k+92163; all peak_valid = 0; acc_we never high.
REQ-034 SHALL cover: cells (row 10, bin 1124) = 50, (row 0, bin 1024) = 30, (row 44, bin 0) = 70, (row 3, bin 2000) = 5, threshold 10 -> the entries are:
- entry 0: count 70, r -1024, angle 176.
- entry 1: count 50, r 100, angle 40.
- entry 2: count 30, r 0, angle 0.
- entry 3: invalid.
REQ-035 SHALL cover: six cells of count 20 at addresses 100, 200, ..., 600 -> the entries hold addresses 100, 200, 300, 400 in that order (tie rule).
REQ-036 SHALL cover: clear_en = 1 with random memory -> after done, every cell reads 0; the peak list matches a reference-model top-4.
REQ-037 SHALL cover: a second start pulse at k+500 -> ignored, and done occurs only at k+92163.
REQ-038 SHALL cover: reset at k+40000 -> busy 0 at once, no done, no acc_we after reset; a new start then completes normally.
